mips_decode_alu: RTL and testbench
==================================

# mips_decode_alu

Single-cycle MIPS decode-and-execute slice: decodes the 32-bit instruction word into the 7-bit control bundle and 3-bit ALU operation, extends the 16-bit immediate, selects ALU operand B, and computes the 32-bit ALU result and zero flag. It sits between the register file (supplying `read_data_1` and `read_data_2`) and the memory and write-back muxes in the core. All outputs are registered, giving one cycle of latency.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clock`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low. Clears all output registers.
- `instruction`  in  32  Instruction word. Fields: opcode [31:26], funct [5:0], imm [15:0].
- `read_data_1`  in  32  Register file port 1, the rs value. Drives ALU operand A.
- `read_data_2`  in  32  Register file port 2, the rt value. Drives ALU operand B when ALUSrc=0.
- `signals`  out  7  Registered control bundle:
  - bit 0 RegDst
  - bit 1 Branch
  - bit 2 MemRead
  - bit 3 MemtoReg
  - bit 4 MemWrite
  - bit 5 ALUSrc
  - bit 6 RegWrite
- `alu_op`  out  3  Registered ALU operation code.
- `imm_ext`  out  32  Registered extended immediate.
- `alu_result`  out  32  Registered ALU result.
- `zero`  out  1  Registered; 1 when the ALU result equals 0.

## Operation
- **ALU operation codes.** B is the selected operand B. All arithmetic wraps modulo 2^32; there is no overflow flag.
  - 000: A & B
  - 001: A | B
  - 010: A + B
  - 011: A ^ B
  - 100: ~(A | B)
  - 101: SLTU, unsigned A < B, result 1 or 0
  - 110: A − B
  - 111: SLT, signed A < B, result 1 or 0
- **Extender.**
  - Sign-extend mode: imm_ext = {16{imm[15]}, imm}.
  - Zero-extend mode: imm_ext = {16'h0, imm}.
- **Operand B.** B = ALUSrc ? imm_ext : read_data_2.
- **Zero flag.** zero = (ALU result == 0), evaluated on the same combinational result that is registered into `alu_result`.
- **Decode by opcode.** Format is signals value / ALU op / extend mode.
  - 000000 R-type: 0x41 (RegDst, RegWrite), ALU op from funct, sign extend.
    - funct 100000 add → 010
    - funct 100010 sub → 110
    - funct 100100 and → 000
    - funct 100101 or → 001
    - funct 100110 xor → 011
    - funct 100111 nor → 100
    - funct 101010 slt → 111
    - funct 101011 sltu → 101
    - Any other funct: signals 0x00, ALU op 010.
  - 001000 addi: 0x60, 010, sign.
  - 001010 slti: 0x60, 111, sign.
  - 001011 sltiu: 0x60, 101, sign.
  - 001100 andi: 0x60, 000, zero.
  - 001101 ori: 0x60, 001, zero.
  - 001110 xori: 0x60, 011, zero.
  - 100011 lw: 0x6C (ALUSrc, MemRead, MemtoReg, RegWrite), 010, sign.
  - 101011 sw: 0x30 (ALUSrc, MemWrite), 010, sign.
  - 000100 beq: 0x02 (Branch), 110, sign.
  - Any other opcode: 0x00, 010, sign. The ALU still computes, so the outputs are harmless.
- **Combinational path.** Decode, extend, mux and ALU form one combinational path from the inputs to the output registers. No other internal state exists.

## Timing
- Every rising edge of `clock` while `reset`=1 captures the decode and ALU results for the inputs present before that edge. Latency is exactly 1 cycle, with a new result every cycle; there is no handshake.
- `reset`=0 immediately and asynchronously forces all outputs to 0, independent of the clock: signals=0, alu_op=000, imm_ext=0, alu_result=0, zero=0.
- Reset asserted mid-operation discards any in-flight result.
- On release of `reset`, the first rising edge loads valid data.

## Test plan
- **Reset.** Hold reset=0 with instruction=0x2008FFFF, then toggle the clock → all outputs stay 0. Release reset and apply one edge → signals=0x60, alu_op=010, imm_ext=0xFFFFFFFF.
- **addi, zero flag.** instruction=0x2008FFFF, rd1=0x00000001 → alu_result=0x00000000, zero=1, output one cycle after the edge.
- **R-type sub and slt.**
  - funct 100010, rd1=5, rd2=7 → alu_result=0xFFFFFFFE, zero=0, signals=0x41, alu_op=110.
  - funct 101010, same operands → alu_result=1.
- **ori zero-extend.** instruction=0x3508F000, rd1=0x00000001 → imm_ext=0x0000F000, alu_result=0x0000F001.
- **lw, sw, beq.**
  - lw with imm 0x0004 and rd1=0x100 → alu_result=0x104, signals=0x6C.
  - sw with the same operands → signals=0x30.
  - beq with rd1=rd2=0x1234 → zero=1, signals=0x02.
- **Boundary values.**
  - ADD of 0xFFFFFFFF and 1 → 0, zero=1.
  - sltiu with rd1=1 and imm 0xFFFF → 1.
  - slti with rd1=1 and imm 0xFFFF → 0.
  - Unknown opcode 111111 → signals=0x00.

Source files
------------

// File: rtl/mips_decode_alu_if.sv
// Bus between the register-file/fetch side and the decode-and-execute slice.
// The master drives the instruction and operands; the slave returns the registered results.
interface mips_decode_alu_if;
   logic [31:0] instruction;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic [6:0]  signals;
   logic [2:0]  alu_op;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        zero;

   modport master (
      output instruction, read_data_1, read_data_2,
      input  signals, alu_op, imm_ext, alu_result, zero
   );

   modport slave (
      input  instruction, read_data_1, read_data_2,
      output signals, alu_op, imm_ext, alu_result, zero
   );
endinterface

// File: rtl/mips_decode_alu.sv
// Single-cycle MIPS decode-and-execute slice: control decode, immediate extend,
// operand-B mux and ALU, all captured into output registers (one cycle latency).
module mips_decode_alu (
   input logic              clock,
   input logic              reset,
   mips_decode_alu_if.slave bus
);

   localparam logic [2:0] AluAnd  = 3'b000;
   localparam logic [2:0] AluOr   = 3'b001;
   localparam logic [2:0] AluAdd  = 3'b010;
   localparam logic [2:0] AluXor  = 3'b011;
   localparam logic [2:0] AluNor  = 3'b100;
   localparam logic [2:0] AluSltu = 3'b101;
   localparam logic [2:0] AluSub  = 3'b110;
   localparam logic [2:0] AluSlt  = 3'b111;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [6:0]  signals_d, signals_q;
   logic [2:0]  alu_op_d, alu_op_q;
   logic [31:0] imm_ext_d, imm_ext_q;
   logic [31:0] alu_result_d, alu_result_q;
   logic        zero_q;
   logic        sign_ext;
   logic [31:0] op_a, op_b;
   logic        unused_fields;

   assign opcode        = bus.instruction[31:26];
   assign funct         = bus.instruction[5:0];
   assign imm           = bus.instruction[15:0];
   // rs/rt/rd/shamt fields are resolved by the register file, not here
   assign unused_fields = ^bus.instruction[25:16];

   always_comb begin
      signals_d = 7'h00;
      alu_op_d  = AluAdd;
      sign_ext  = 1'b1;
      unique case (opcode)
         6'b000000: begin
            signals_d = 7'h41;
            unique case (funct)
               6'b100000: alu_op_d = AluAdd;
               6'b100010: alu_op_d = AluSub;
               6'b100100: alu_op_d = AluAnd;
               6'b100101: alu_op_d = AluOr;
               6'b100110: alu_op_d = AluXor;
               6'b100111: alu_op_d = AluNor;
               6'b101010: alu_op_d = AluSlt;
               6'b101011: alu_op_d = AluSltu;
               default: begin
                  signals_d = 7'h00;
                  alu_op_d  = AluAdd;
               end
            endcase
         end
         6'b001000: begin signals_d = 7'h60; alu_op_d = AluAdd;  end
         6'b001010: begin signals_d = 7'h60; alu_op_d = AluSlt;  end
         6'b001011: begin signals_d = 7'h60; alu_op_d = AluSltu; end
         6'b001100: begin signals_d = 7'h60; alu_op_d = AluAnd; sign_ext = 1'b0; end
         6'b001101: begin signals_d = 7'h60; alu_op_d = AluOr;  sign_ext = 1'b0; end
         6'b001110: begin signals_d = 7'h60; alu_op_d = AluXor; sign_ext = 1'b0; end
         6'b100011: begin signals_d = 7'h6C; alu_op_d = AluAdd; end
         6'b101011: begin signals_d = 7'h30; alu_op_d = AluAdd; end
         6'b000100: begin signals_d = 7'h02; alu_op_d = AluSub; end
         default: begin
            signals_d = 7'h00;
            alu_op_d  = AluAdd;
         end
      endcase
   end

   assign imm_ext_d = sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
   assign op_a      = bus.read_data_1;
   // signals bit 5 is ALUSrc
   assign op_b      = signals_d[5] ? imm_ext_d : bus.read_data_2;

   always_comb begin
      alu_result_d = 32'h0;
      unique case (alu_op_d)
         AluAnd:  alu_result_d = op_a & op_b;
         AluOr:   alu_result_d = op_a | op_b;
         AluAdd:  alu_result_d = op_a + op_b;
         AluXor:  alu_result_d = op_a ^ op_b;
         AluNor:  alu_result_d = ~(op_a | op_b);
         AluSltu: alu_result_d = {31'h0, op_a < op_b};
         AluSub:  alu_result_d = op_a - op_b;
         AluSlt:  alu_result_d = {31'h0, $signed(op_a) < $signed(op_b)};
         default: alu_result_d = 32'h0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         signals_q    <= 7'h00;
         alu_op_q     <= 3'b000;
         imm_ext_q    <= 32'h0;
         alu_result_q <= 32'h0;
         zero_q       <= 1'b0;
      end else begin
         signals_q    <= signals_d;
         alu_op_q     <= alu_op_d;
         imm_ext_q    <= imm_ext_d;
         alu_result_q <= alu_result_d;
         zero_q       <= (alu_result_d == 32'h0);
      end
   end

   assign bus.signals    = signals_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.imm_ext    = imm_ext_q;
   assign bus.alu_result = alu_result_q;
   assign bus.zero       = zero_q;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Bench for mips_decode_alu: an instruction-level reference model checked every
// cycle, plus hand-computed literal expectations from the test plan.
module tb_mips_decode_alu;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mips_decode_alu_if bus ();

   mips_decode_alu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Instruction-level semantics: each mnemonic computes its result directly.
   function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, output logic [6:0] s,
                                 output logic [2:0] op, output logic [31:0] imm,
                                 output logic [31:0] res);
      logic [31:0] se;
      logic [31:0] ze;
      se  = {{16{ins[15]}}, ins[15:0]};
      ze  = {16'h0000, ins[15:0]};
      s   = 7'h00;
      op  = 3'd2;
      imm = se;
      res = a + b;
      case (ins[31:26])
         6'h00: begin
            s = 7'h41;
            case (ins[5:0])
               6'h20: begin op = 3'd2; res = a + b; end
               6'h22: begin op = 3'd6; res = a - b; end
               6'h24: begin op = 3'd0; res = a & b; end
               6'h25: begin op = 3'd1; res = a | b; end
               6'h26: begin op = 3'd3; res = a ^ b; end
               6'h27: begin op = 3'd4; res = ~(a | b); end
               6'h2A: begin op = 3'd7; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
               6'h2B: begin op = 3'd5; res = (a < b) ? 32'd1 : 32'd0; end
               default: begin s = 7'h00; op = 3'd2; res = a + b; end
            endcase
         end
         6'h08: begin s = 7'h60; op = 3'd2; res = a + se; end
         6'h0A: begin s = 7'h60; op = 3'd7; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
         6'h0B: begin s = 7'h60; op = 3'd5; res = (a < se) ? 32'd1 : 32'd0; end
         6'h0C: begin s = 7'h60; op = 3'd0; imm = ze; res = a & ze; end
         6'h0D: begin s = 7'h60; op = 3'd1; imm = ze; res = a | ze; end
         6'h0E: begin s = 7'h60; op = 3'd3; imm = ze; res = a ^ ze; end
         6'h23: begin s = 7'h6C; op = 3'd2; res = a + se; end
         6'h2B: begin s = 7'h30; op = 3'd2; res = a + se; end
         6'h04: begin s = 7'h02; op = 3'd6; res = a - b; end
         default: begin s = 7'h00; op = 3'd2; res = a + b; end
      endcase
   endfunction

   logic [6:0]  exp_sig  = '0;
   logic [2:0]  exp_op   = '0;
   logic [31:0] exp_imm  = '0;
   logic [31:0] exp_res  = '0;
   logic        exp_zero = 1'b0;

   always @(posedge clock or negedge reset) begin
      logic [6:0]  s;
      logic [2:0]  op;
      logic [31:0] imm;
      logic [31:0] res;
      if (!reset) begin
         exp_sig  <= '0;
         exp_op   <= '0;
         exp_imm  <= '0;
         exp_res  <= '0;
         exp_zero <= 1'b0;
      end else begin
         model(bus.instruction, bus.read_data_1, bus.read_data_2, s, op, imm, res);
         exp_sig  <= s;
         exp_op   <= op;
         exp_imm  <= imm;
         exp_res  <= res;
         exp_zero <= (res == 32'h0);
      end
   end

   always @(negedge clock) begin
      checks++;
      if ({bus.signals, bus.alu_op, bus.imm_ext, bus.alu_result, bus.zero} !==
          {exp_sig, exp_op, exp_imm, exp_res, exp_zero}) begin
         errors++;
         $display("FAIL model_compare t=%0t got sig=%h op=%h imm=%h res=%h z=%b want sig=%h op=%h imm=%h res=%h z=%b",
                  $time, bus.signals, bus.alu_op, bus.imm_ext, bus.alu_result, bus.zero,
                  exp_sig, exp_op, exp_imm, exp_res, exp_zero);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      #1;
      bus.instruction = ins;
      bus.read_data_1 = a;
      bus.read_data_2 = b;
   endtask

   task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      drive(ins, a, b);
      @(posedge clock);
      #1;
   endtask

   logic [31:0] vec_ins [12] = '{32'h00000024, 32'h00000025, 32'h00000026, 32'h00000027,
                                 32'h0000002B, 32'h0000002A, 32'h3008FF0F, 32'h3908FFFF,
                                 32'h2800FFFE, 32'h2008FFFF, 32'h10000000, 32'h00000022};
   logic [31:0] vec_a   [12] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0000FFFF,
                                 32'h80000000, 32'h80000000, 32'h12345678, 32'h0000AAAA,
                                 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000};
   logic [31:0] vec_b   [12] = '{32'h0FF00FF0, 32'h0F0F0F0F, 32'hFF00FF00, 32'hFFFF0000,
                                 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000002, 32'h00000001};

   initial begin
      reset           = 1'b0;
      bus.instruction = 32'h2008FFFF;
      bus.read_data_1 = 32'h0;
      bus.read_data_2 = 32'h0;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_signals", {25'h0, bus.signals}, 32'h0);
      chk("rst_alu_op", {29'h0, bus.alu_op}, 32'h0);
      chk("rst_imm_ext", bus.imm_ext, 32'h0);
      chk("rst_result", bus.alu_result, 32'h0);
      chk("rst_zero", {31'h0, bus.zero}, 32'h0);

      @(negedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rel_signals", {25'h0, bus.signals}, 32'h60);
      chk("rel_alu_op", {29'h0, bus.alu_op}, 32'h2);
      chk("rel_imm_ext", bus.imm_ext, 32'hFFFFFFFF);

      run(32'h2008FFFF, 32'h1, 32'h0);
      chk("addi_result", bus.alu_result, 32'h0);
      chk("addi_zero", {31'h0, bus.zero}, 32'h1);

      run(32'h00000022, 32'd5, 32'd7);
      chk("sub_result", bus.alu_result, 32'hFFFFFFFE);
      chk("sub_zero", {31'h0, bus.zero}, 32'h0);
      chk("sub_signals", {25'h0, bus.signals}, 32'h41);
      chk("sub_alu_op", {29'h0, bus.alu_op}, 32'h6);

      run(32'h0000002A, 32'd5, 32'd7);
      chk("slt_result", bus.alu_result, 32'h1);

      run(32'h3508F000, 32'h1, 32'h0);
      chk("ori_imm_ext", bus.imm_ext, 32'h0000F000);
      chk("ori_result", bus.alu_result, 32'h0000F001);

      run(32'h8C000004, 32'h100, 32'h0);
      chk("lw_result", bus.alu_result, 32'h104);
      chk("lw_signals", {25'h0, bus.signals}, 32'h6C);

      run(32'hAC000004, 32'h100, 32'h0);
      chk("sw_signals", {25'h0, bus.signals}, 32'h30);
      chk("sw_result", bus.alu_result, 32'h104);

      run(32'h10000000, 32'h1234, 32'h1234);
      chk("beq_zero", {31'h0, bus.zero}, 32'h1);
      chk("beq_signals", {25'h0, bus.signals}, 32'h02);

      run(32'h00000020, 32'hFFFFFFFF, 32'h1);
      chk("add_wrap_result", bus.alu_result, 32'h0);
      chk("add_wrap_zero", {31'h0, bus.zero}, 32'h1);

      run(32'h2C00FFFF, 32'h1, 32'h0);
      chk("sltiu_result", bus.alu_result, 32'h1);

      run(32'h2800FFFF, 32'h1, 32'h0);
      chk("slti_result", bus.alu_result, 32'h0);

      run(32'hFC000000, 32'h3, 32'h4);
      chk("unknown_op_signals", {25'h0, bus.signals}, 32'h0);

      run(32'h0000003F, 32'h3, 32'h4);
      chk("bad_funct_signals", {25'h0, bus.signals}, 32'h0);
      chk("bad_funct_alu_op", {29'h0, bus.alu_op}, 32'h2);
      chk("bad_funct_result", bus.alu_result, 32'h7);

      // Asynchronous reset mid-stream must clear outputs before any clock edge.
      run(32'h00000020, 32'h3, 32'h4);
      chk("pre_reset_result", bus.alu_result, 32'h7);
      @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_result", bus.alu_result, 32'h0);
      chk("async_rst_signals", {25'h0, bus.signals}, 32'h0);
      @(negedge clock);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 12; i++) run(vec_ins[i], vec_a[i], vec_b[i]);

      repeat (2) @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
